// File: rtl/led_pattern_sched.sv
// led_pattern_sched: round-robin scheduler that lends a 12-bit LED bank to one
// of three requesters for a fixed number of prescaler ticks.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[2:0]   level-sensitive requests, bit i = requester i
//   pat0..pat2 12-bit patterns, sampled only at grant time
//   gnt[2:0]   one-hot owner of the bank, zero when idle
//   busy       high while a grant is being shown
//   tick       one-cycle pulse when the prescaler wraps during a grant
//   led[11:0]  registered LED drive (inverted when ACTIVE_LOW != 0)
//
// Build option: define LED_SCHED_ROTATE_EN to rotate the displayed pattern
// left by one on every tick that does not end the grant.
module led_pattern_sched #(
  parameter int unsigned TICK_BITS  = 24,
  parameter int unsigned DWELL      = 12,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [11:0] pat0,
  input  logic [11:0] pat1,
  input  logic [11:0] pat2,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic        tick,
  output logic [11:0] led
);

  localparam int unsigned LED_W  = 12;
  localparam int unsigned STEP_W = 4;
  localparam logic [TICK_BITS-1:0] PRESC_MAX = '1;
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [TICK_BITS-1:0] presc, presc_n;
  logic [STEP_W-1:0]    step, step_n;
  logic [LED_W-1:0]     disp, disp_n;
  logic [1:0]           last_gnt, last_gnt_n;
  logic [2:0]           gnt_n;
  logic                 busy_n;
  logic                 tick_n;
  logic [1:0]           winner;
  logic [LED_W-1:0]     pat_sel;

  // Round-robin pick, searching from the requester after last.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    pick = 2'd0;
    case (last)
      2'd0: begin
        if      (r[1]) pick = 2'd1;
        else if (r[2]) pick = 2'd2;
        else           pick = 2'd0;
      end
      2'd1: begin
        if      (r[2]) pick = 2'd2;
        else if (r[0]) pick = 2'd0;
        else           pick = 2'd1;
      end
      default: begin
        if      (r[0]) pick = 2'd0;
        else if (r[1]) pick = 2'd1;
        else           pick = 2'd2;
      end
    endcase
    return pick;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

  // Winner and its pattern for an arbitration from IDLE.
  always_comb begin
    winner = rr_pick(req, last_gnt);
    case (winner)
      2'd0:    pat_sel = pat0;
      2'd1:    pat_sel = pat1;
      default: pat_sel = pat2;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    presc_n    = presc;
    step_n     = step;
    disp_n     = disp;
    last_gnt_n = last_gnt;
    gnt_n      = 3'b000;
    busy_n     = 1'b0;
    tick_n     = 1'b0;

    case (state)
      IDLE: begin
        disp_n = '0;
        if (req != 3'b000) begin
          state_n    = SHOW;
          disp_n     = pat_sel;
          gnt_n      = to_onehot(winner);
          busy_n     = 1'b1;
          presc_n    = '0;
          step_n     = '0;
          last_gnt_n = winner;
        end
      end

      SHOW: begin
        gnt_n   = to_onehot(last_gnt);
        busy_n  = 1'b1;
        presc_n = TICK_BITS'(presc + 1'b1);
        if (!req[last_gnt]) begin
          // Owner withdrew: release at once, no further ticks counted.
          state_n = GAP;
          gnt_n   = 3'b000;
          busy_n  = 1'b0;
          disp_n  = '0;
          presc_n = '0;
        end else if (presc == PRESC_MAX) begin
          step_n = STEP_W'(step + 1'b1);
          if (step == STEP_LAST) begin
            state_n = GAP;
            gnt_n   = 3'b000;
            busy_n  = 1'b0;
            disp_n  = '0;
          end else begin
`ifdef LED_SCHED_ROTATE_EN
            disp_n = {disp[LED_W-2:0], disp[LED_W-1]};
`else
            disp_n = disp;
`endif
          end
        end
      end

      GAP: begin
        state_n = IDLE;
        disp_n  = '0;
      end

      default: begin
        state_n = IDLE;
        disp_n  = '0;
      end
    endcase

    // Registered tick lines up with the cycle where the prescaler sits at max.
    tick_n = (state_n == SHOW) && (presc_n == PRESC_MAX);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      step     <= '0;
      disp     <= '0;
      last_gnt <= 2'd2;
      gnt      <= 3'b000;
      busy     <= 1'b0;
      tick     <= 1'b0;
      led      <= (ACTIVE_LOW != 0) ? {LED_W{1'b1}} : {LED_W{1'b0}};
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      step     <= step_n;
      disp     <= disp_n;
      last_gnt <= last_gnt_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      tick     <= tick_n;
      led      <= (ACTIVE_LOW != 0) ? ~disp_n : disp_n;
    end
  end

endmodule
